cernbe_mem_target: RTL and testbench

- Downstream target for one CERN-BE memory bus produced by the generated Wishbone-to-CERN-BE decoder (VMEAddr/VMERdMem/VMEWrMem/VMERdDone/VMEWrDone).
- Implements a 2**ADDR_WIDTH-word memory with programmable read and write acknowledge latency.
- Provides a user-side read port for application logic.
- Latches each bus request, serialises overlapping read and write requests, and returns exactly one Done pulse per accepted strobe.

---
 rtl/cernbe_mem_pkg.sv | 20 ++
 rtl/cernbe_mem_dpram.sv | 60 ++++++
 rtl/cernbe_mem_target.sv | 201 ++++++++++++++++++++
 tb/tb_cernbe_mem_target.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cernbe_mem_pkg.sv
// Shared types and constants for the CERN-BE memory target.
// State encoding, latency counter width and the legal latency range.
package cernbe_mem_pkg;

  localparam int LAT_CNT_W   = 3;
  localparam int MIN_LATENCY = 1;
  localparam int MAX_LATENCY = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

  // True when a latency parameter fits the 3-bit countdown.
  function automatic bit latency_ok(input int lat);
    return (lat >= MIN_LATENCY) && (lat <= MAX_LATENCY);
  endfunction

endpackage

// File: rtl/cernbe_mem_dpram.sv
// Dual-port RAM behind the CERN-BE memory target.
// Port A: bus write plus bus read (separate addresses, registered read,
// write-first when both hit the same word). Port B: registered user read.
// Under CERNBE_MEM_USR_WR_EN port B can also write; a same-cycle port A
// write to the same word wins and the port B write is dropped.
// No reset: contents survive reset.
module cernbe_mem_dpram
  import cernbe_mem_pkg::*;
#(
  parameter int AW = 11,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_waddr,
  input  logic [DW-1:0] a_wdata,
  input  logic [AW-1:0] a_raddr,
  output logic [DW-1:0] a_rdata,
`ifdef CERNBE_MEM_USR_WR_EN
  input  logic          b_we,
  input  logic [DW-1:0] b_wdata,
`endif
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

`ifdef CERNBE_MEM_USR_WR_EN
  logic b_wr_ok;
  assign b_wr_ok = b_we && !(a_we && (a_waddr == b_addr));
`endif

  // Array update: bus write, then user write when it does not collide.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_waddr] <= a_wdata;
`ifdef CERNBE_MEM_USR_WR_EN
    if (b_wr_ok) mem[b_addr] <= b_wdata;
`endif
  end

  // Port A read: forwards a same-cycle write so a queued read sees it.
  always_ff @(posedge clk) begin
    if (a_we && (a_waddr == a_raddr)) begin
      a_rdata <= a_wdata;
`ifdef CERNBE_MEM_USR_WR_EN
    end else if (b_wr_ok && (b_addr == a_raddr)) begin
      a_rdata <= b_wdata;
`endif
    end else begin
      a_rdata <= mem[a_raddr];
    end
  end

  // Port B read: plain registered read, returns old data on collision.
  always_ff @(posedge clk) begin
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/cernbe_mem_target.sv
// CERN-BE memory bus target: 2**ADDR_WIDTH words with programmable
// read/write acknowledge latency and a user-side read port.
// Optional macro CERNBE_MEM_USR_WR_EN adds a user write port.
//
// Bus handshake: VMERdMem_i / VMEWrMem_i are single-cycle strobes sampled
// on the rising clock; address and write data are captured in that cycle.
// Every accepted strobe yields exactly one single-cycle VMERdDone_o /
// VMEWrDone_o; read data is valid only in the VMERdDone_o cycle (zero
// otherwise). One read and one write may be outstanding together; a second
// strobe of a type already outstanding is dropped and sets proto_err_o.
module cernbe_mem_target
  import cernbe_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADDR_WIDTH-1:0] VMEAddr_i,
  input  logic [DATA_WIDTH-1:0] VMEWrData_i,
  input  logic                  VMERdMem_i,
  input  logic                  VMEWrMem_i,
  output logic [DATA_WIDTH-1:0] VMERdData_o,
  output logic                  VMERdDone_o,
  output logic                  VMEWrDone_o,
  input  logic [ADDR_WIDTH-1:0] usr_addr_i,
  output logic [DATA_WIDTH-1:0] usr_data_o,
`ifdef CERNBE_MEM_USR_WR_EN
  input  logic                  usr_we_i,
  input  logic [DATA_WIDTH-1:0] usr_wdata_i,
`endif
  output logic                  proto_err_o
);

  if (!latency_ok(RD_LATENCY)) begin : g_rd_lat_bad
    $error("RD_LATENCY must be within 1..7");
  end
  if (!latency_ok(WR_LATENCY)) begin : g_wr_lat_bad
    $error("WR_LATENCY must be within 1..7");
  end

  localparam logic [LAT_CNT_W-1:0] RD_LOAD = LAT_CNT_W'(RD_LATENCY - 1);
  localparam logic [LAT_CNT_W-1:0] WR_LOAD = LAT_CNT_W'(WR_LATENCY - 1);

  state_e                 state, state_nxt;
  logic [LAT_CNT_W-1:0]   cnt, cnt_nxt;
  logic                   rd_pend, rd_pend_nxt;
  logic                   wr_pend, wr_pend_nxt;
  logic                   rd_take, wr_take, err_hit;
  logic                   rd_done, wr_done;
  logic                   proto_err;
  logic                   usr_vld;
  logic [ADDR_WIDTH-1:0]  rd_addr, wr_addr, ram_raddr;
  logic [DATA_WIDTH-1:0]  wr_data, ram_a_q, ram_b_q;

  // State, countdown, pending flags and sticky error.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_pend   <= 1'b0;
      wr_pend   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rd_pend   <= rd_pend_nxt;
      wr_pend   <= wr_pend_nxt;
      proto_err <= proto_err | err_hit;
    end
  end

  // Next state: accept/queue/reject strobes and fire Done at count zero.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rd_pend_nxt = rd_pend;
    wr_pend_nxt = wr_pend;
    rd_take     = 1'b0;
    wr_take     = 1'b0;
    err_hit     = 1'b0;
    rd_done     = 1'b0;
    wr_done     = 1'b0;
    case (state)
      IDLE: begin
        if (VMEWrMem_i) begin
          wr_take   = 1'b1;
          state_nxt = WR_WAIT;
          cnt_nxt   = WR_LOAD;
          if (VMERdMem_i) begin
            rd_take     = 1'b1;
            rd_pend_nxt = 1'b1;
          end
        end else if (VMERdMem_i) begin
          rd_take   = 1'b1;
          state_nxt = RD_WAIT;
          cnt_nxt   = RD_LOAD;
        end
      end
      WR_WAIT: begin
        if (VMEWrMem_i) err_hit = 1'b1;
        if (VMERdMem_i) begin
          if (rd_pend) begin
            err_hit = 1'b1;
          end else begin
            rd_take     = 1'b1;
            rd_pend_nxt = 1'b1;
          end
        end
        if (cnt == '0) begin
          wr_done = 1'b1;
          if (rd_pend || rd_take) begin
            state_nxt   = RD_WAIT;
            cnt_nxt     = RD_LOAD;
            rd_pend_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - LAT_CNT_W'(1);
        end
      end
      RD_WAIT: begin
        if (VMERdMem_i) err_hit = 1'b1;
        if (VMEWrMem_i) begin
          if (wr_pend) begin
            err_hit = 1'b1;
          end else begin
            wr_take     = 1'b1;
            wr_pend_nxt = 1'b1;
          end
        end
        if (cnt == '0) begin
          rd_done = 1'b1;
          if (wr_pend || wr_take) begin
            state_nxt   = WR_WAIT;
            cnt_nxt     = WR_LOAD;
            wr_pend_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - LAT_CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture: address/data latched in the accepted strobe cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_addr <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      if (rd_take) rd_addr <= VMEAddr_i;
      if (wr_take) begin
        wr_addr <= VMEAddr_i;
        wr_data <= VMEWrData_i;
      end
    end
  end

  // Marks the user read register as holding a real RAM word after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) usr_vld <= 1'b0;
    else          usr_vld <= 1'b1;
  end

  // RAM port A tracks the address the read latch will hold next cycle, so
  // the registered word is always current when the read Done fires.
  assign ram_raddr = rd_take ? VMEAddr_i : rd_addr;

  cernbe_mem_dpram #(
    .AW (ADDR_WIDTH),
    .DW (DATA_WIDTH)
  ) u_ram (
    .clk     (clk_i),
    .a_we    (wr_done),
    .a_waddr (wr_addr),
    .a_wdata (wr_data),
    .a_raddr (ram_raddr),
    .a_rdata (ram_a_q),
`ifdef CERNBE_MEM_USR_WR_EN
    .b_we    (usr_we_i),
    .b_wdata (usr_wdata_i),
`endif
    .b_addr  (usr_addr_i),
    .b_rdata (ram_b_q)
  );

  assign VMERdDone_o = rd_done;
  assign VMEWrDone_o = wr_done;
  assign VMERdData_o = rd_done ? ram_a_q : '0;
  assign usr_data_o  = usr_vld ? ram_b_q : '0;
  assign proto_err_o = proto_err;

endmodule

// File: tb/tb_cernbe_mem_target.sv
`timescale 1ns/1ps
module tb_cernbe_mem_target;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int NI = 2;   // instance 0: default latencies, 1: RD=7 WR=3

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          rd_mem, wr_mem;
  logic [AW-1:0] usr_addr;
  logic [DW-1:0] rd_data0, rd_data1, usr_data0, usr_data1;
  logic          rd_done0, rd_done1, wr_done0, wr_done1, err0, err1;
`ifdef CERNBE_MEM_USR_WR_EN
  logic          usr_we;
  logic [DW-1:0] usr_wdata;
`endif

  cernbe_mem_target dut0 (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .VMEAddr_i   (addr),
    .VMEWrData_i (wdata),
    .VMERdMem_i  (rd_mem),
    .VMEWrMem_i  (wr_mem),
    .VMERdData_o (rd_data0),
    .VMERdDone_o (rd_done0),
    .VMEWrDone_o (wr_done0),
    .usr_addr_i  (usr_addr),
    .usr_data_o  (usr_data0),
`ifdef CERNBE_MEM_USR_WR_EN
    .usr_we_i    (usr_we),
    .usr_wdata_i (usr_wdata),
`endif
    .proto_err_o (err0)
  );

  cernbe_mem_target #(
    .RD_LATENCY (7),
    .WR_LATENCY (3)
  ) dut1 (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .VMEAddr_i   (addr),
    .VMEWrData_i (wdata),
    .VMERdMem_i  (rd_mem),
    .VMEWrMem_i  (wr_mem),
    .VMERdData_o (rd_data1),
    .VMERdDone_o (rd_done1),
    .VMEWrDone_o (wr_done1),
    .usr_addr_i  (usr_addr),
    .usr_data_o  (usr_data1),
`ifdef CERNBE_MEM_USR_WR_EN
    .usr_we_i    (1'b0),
    .usr_wdata_i ('0),
`endif
    .proto_err_o (err1)
  );

  // ---------------- reference model ----------------
  // Transaction-level: a strobe is rejected if the same type is still
  // outstanding; otherwise its Done lands L cycles after the later of the
  // strobe cycle and the last outstanding Done. Reads return the model
  // memory as it stands after all earlier accepted writes.
  typedef struct packed {
    logic          is_wr;
    int            done;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q0[$];
  exp_t          exp_q1[$];
  logic [DW-1:0] mdl_mem [NI][16];
  int            last_wr [NI];
  int            last_rd [NI];
  bit            mdl_err [NI];

  int checks = 0;
  int errors = 0;

  function automatic int lat_of(input int inst, input bit is_wr);
    if (inst == 0) return is_wr ? 1 : 2;
    return is_wr ? 3 : 7;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int idx);
    case (idx)
      0:       return AW'(11'h005);
      1:       return AW'(11'h010);
      2:       return AW'(11'h001);
      default: return AW'(idx * 131);
    endcase
  endfunction

  function automatic int q_size(input int inst);
    return (inst == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic exp_t q_front(input int inst);
    return (inst == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  function automatic exp_t q_pop(input int inst);
    if (inst == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  task automatic model_strobe(input int inst, input bit is_wr, input int idx,
                              input logic [DW-1:0] d, input int t);
    int   base;
    int   busy;
    exp_t e;
    busy = is_wr ? last_wr[inst] : last_rd[inst];
    if (busy >= t) begin
      mdl_err[inst] = 1'b1;
      return;
    end
    base = (last_wr[inst] > last_rd[inst]) ? last_wr[inst] : last_rd[inst];
    if (base < t) base = t;
    e.is_wr = is_wr;
    e.done  = base + lat_of(inst, is_wr);
    if (is_wr) begin
      mdl_mem[inst][idx] = d;
      e.data             = d;
      last_wr[inst]      = e.done;
    end else begin
      e.data        = mdl_mem[inst][idx];
      last_rd[inst] = e.done;
    end
    if (inst == 0) exp_q0.push_back(e);
    else           exp_q1.push_back(e);
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    for (int i = 0; i < NI; i++) begin
      last_wr[i] = -100;
      last_rd[i] = -100;
      mdl_err[i] = 1'b0;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic check_inst(input int inst, input logic rdd, input logic wrd,
                            input logic [DW-1:0] rdata);
    exp_t e;
    if (q_size(inst) > 0 && q_front(inst).done < cyc) begin
      e = q_pop(inst);
      checks++;
      errors++;
      $display("FAIL done_missed inst%0d: no %s done seen, required at cycle %0d (now %0d)",
               inst, e.is_wr ? "wr" : "rd", e.done, cyc);
    end
    if (rdd || wrd) begin
      checks++;
      if (q_size(inst) == 0) begin
        errors++;
        $display("FAIL unexpected_done inst%0d cycle %0d: got rd=%0b wr=%0b, required none",
                 inst, cyc, rdd, wrd);
      end else begin
        e = q_pop(inst);
        if (e.done != cyc || rdd != !e.is_wr || wrd != e.is_wr) begin
          errors++;
          $display("FAIL done_timing inst%0d: got rd=%0b wr=%0b at cycle %0d, required %s at cycle %0d",
                   inst, rdd, wrd, cyc, e.is_wr ? "wr" : "rd", e.done);
        end else if (!e.is_wr) begin
          checks++;
          if (rdata !== e.data) begin
            errors++;
            $display("FAIL rd_data inst%0d cycle %0d: got %h required %h",
                     inst, cyc, rdata, e.data);
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    check_inst(0, rd_done0, wr_done0, rd_data0);
    check_inst(1, rd_done1, wr_done1, rd_data1);
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // One bus cycle starting just after a rising edge.
  task automatic bus_cycle(input bit rd, input bit wr, input int idx,
                           input logic [DW-1:0] d);
    rd_mem = rd;
    wr_mem = wr;
    addr   = (rd || wr) ? addr_of(idx) : AW'($urandom);
    wdata  = wr ? d : DW'($urandom);
    for (int i = 0; i < NI; i++) begin
      if (wr) model_strobe(i, 1'b1, idx, d, cyc);
      if (rd) model_strobe(i, 1'b0, idx, d, cyc);
    end
    @(posedge clk);
    #1;
    rd_mem = 1'b0;
    wr_mem = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 0, '0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q0.size() > 0 || exp_q1.size() > 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d outstanding after 200 cycles, required 0",
               exp_q0.size(), exp_q1.size());
      exp_q0.delete();
      exp_q1.delete();
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_rd_done0", DW'(rd_done0), '0);
    chk("rst_wr_done0", DW'(wr_done0), '0);
    chk("rst_rd_data0", rd_data0, '0);
    chk("rst_usr_data0", usr_data0, '0);
    chk("rst_err0", DW'(err0), '0);
    chk("rst_rd_done1", DW'(rd_done1), '0);
    chk("rst_wr_done1", DW'(wr_done1), '0);
    chk("rst_rd_data1", rd_data1, '0);
    chk("rst_usr_data1", usr_data1, '0);
    chk("rst_err1", DW'(err1), '0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs checked before any edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] old_v;
    logic [DW-1:0] new_v;
    addr     = '0;
    wdata    = '0;
    rd_mem   = 1'b0;
    wr_mem   = 1'b0;
    usr_addr = '0;
`ifdef CERNBE_MEM_USR_WR_EN
    usr_we    = 1'b0;
    usr_wdata = '0;
`endif
    model_reset();
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Prefill every address the bench will read.
    for (int i = 0; i < 16; i++) begin
      bus_cycle(1'b0, 1'b1, i, DW'($urandom));
      drain();
    end

    // Write then read back 0x005.
    bus_cycle(1'b0, 1'b1, 0, 32'hDEADBEEF);
    drain();
    bus_cycle(1'b1, 1'b0, 0, '0);
    drain();
    chk("err_after_basic0", DW'(err0), DW'(mdl_err[0]));

    // Write and read 0x010 in the same cycle: write first.
    bus_cycle(1'b1, 1'b1, 1, 32'h12345678);
    drain();

    // Read issued while a write is in flight.
    bus_cycle(1'b0, 1'b1, 3, 32'hCAFE0003);
    bus_cycle(1'b1, 1'b0, 3, '0);
    drain();
    chk("err_clean0", DW'(err0), '0);
    chk("err_clean1", DW'(err1), '0);

    // Back-to-back reads: second one dropped, sticky error.
    bus_cycle(1'b1, 1'b0, 2, '0);
    bus_cycle(1'b1, 1'b0, 2, '0);
    drain();
    idle(3);
    chk("err_dup_rd0", DW'(err0), 32'd1);
    chk("err_dup_rd1", DW'(err1), 32'd1);
    do_reset();
    chk("err_cleared0", DW'(err0), '0);

    // Reset while a read is outstanding: no Done at all.
    bus_cycle(1'b1, 1'b0, 2, '0);
    do_reset();
    idle(12);
    bus_cycle(1'b1, 1'b0, 2, '0);
    drain();

    // User port, including old data on a same-cycle bus write.
    usr_addr = addr_of(4);
    idle(2);
    chk("usr_rd0", usr_data0, mdl_mem[0][4]);
    chk("usr_rd1", usr_data1, mdl_mem[1][4]);
    old_v = mdl_mem[0][4];
    new_v = old_v ^ 32'h5A5A_0F0F;
    bus_cycle(1'b0, 1'b1, 4, new_v);
    @(posedge clk);
    #1;
    chk("usr_old_on_collision", usr_data0, old_v);
    @(posedge clk);
    #1;
    chk("usr_new_after_write", usr_data0, new_v);
    drain();
    idle(2);
    chk("usr_new1", usr_data1, new_v);

`ifdef CERNBE_MEM_USR_WR_EN
    // Same-address collision: bus write wins.
    bus_cycle(1'b0, 1'b1, 5, 32'h5555FFFF);
    usr_we    = 1'b1;
    usr_addr  = addr_of(5);
    usr_wdata = 32'hAAAA0000;
    @(posedge clk);
    #1;
    usr_we = 1'b0;
    drain();
    bus_cycle(1'b1, 1'b0, 5, '0);
    drain();
    // Different addresses: both land.
    bus_cycle(1'b0, 1'b1, 6, 32'h5555FFFF);
    usr_we    = 1'b1;
    usr_addr  = addr_of(7);
    usr_wdata = 32'hAAAA0000;
    mdl_mem[0][7] = 32'hAAAA0000;
    @(posedge clk);
    #1;
    usr_we = 1'b0;
    drain();
    bus_cycle(1'b1, 1'b0, 6, '0);
    drain();
    bus_cycle(1'b1, 1'b0, 7, '0);
    drain();
`endif

    // Randomised traffic rounds, each closed by an error check and reset.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 150; k++) begin
        bus_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15), DW'($urandom));
      end
      drain();
      idle(2);
      chk("rand_err0", DW'(err0), DW'(mdl_err[0]));
      chk("rand_err1", DW'(err1), DW'(mdl_err[1]));
      do_reset();
      idle(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
